// File: rtl/ysyx_22050854_wbu.sv
// Writeback unit: retires one instruction per handshake, waits for and extends load data,
// and drives a registered register-file write port. Difftest commit port: YSYX_22050854_WBU_DIFFTEST_EN.
module ysyx_22050854_wbu (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_pc,
    input  logic [4:0]  in_rd,
    input  logic        in_rd_wen,
    input  logic [63:0] in_result,
    input  logic        in_is_load,
    input  logic [2:0]  in_ld_funct3,
    input  logic [2:0]  in_addr_lo,
    input  logic        mem_rvalid,
    input  logic [63:0] mem_rdata,
    output logic        rf_wen,
    output logic [4:0]  rf_waddr,
    output logic [63:0] rf_wdata,
    output logic [63:0] instret,
    output logic        commit_valid,
    output logic [63:0] commit_pc
);

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_MEM = 1'b1
    } state_e;

    state_e      state_q, state_d;
    logic [4:0]  rd_q;
    logic        rd_wen_q;
    logic [2:0]  funct3_q;
    logic [2:0]  addr_lo_q;
    logic        rf_wen_q;
    logic [4:0]  rf_waddr_q;
    logic [63:0] rf_wdata_q;
    logic [63:0] instret_q;

    logic        accept;
    logic        retire;
    logic        ret_wen;
    logic [4:0]  ret_rd;
    logic [63:0] ret_data;
    logic [63:0] sh;
    logic [63:0] ld_data;

    assign in_ready = (state_q == IDLE);
    assign accept   = in_ready && in_valid;

    assign sh = mem_rdata >> {addr_lo_q, 3'b000};

    always_comb begin
        ld_data = sh;
        case (funct3_q)
            3'b000:  ld_data = {{56{sh[7]}},  sh[7:0]};
            3'b001:  ld_data = {{48{sh[15]}}, sh[15:0]};
            3'b010:  ld_data = {{32{sh[31]}}, sh[31:0]};
            3'b100:  ld_data = {56'd0, sh[7:0]};
            3'b101:  ld_data = {48'd0, sh[15:0]};
            3'b110:  ld_data = {32'd0, sh[31:0]};
            default: ld_data = sh;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        retire   = 1'b0;
        ret_wen  = 1'b0;
        ret_rd   = rd_q;
        ret_data = ld_data;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (in_is_load) begin
                        state_d = WAIT_MEM;
                    end else begin
                        retire   = 1'b1;
                        ret_wen  = in_rd_wen;
                        ret_rd   = in_rd;
                        ret_data = in_result;
                    end
                end
            end
            WAIT_MEM: begin
                if (mem_rvalid) begin
                    state_d  = IDLE;
                    retire   = 1'b1;
                    ret_wen  = rd_wen_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rd_q       <= '0;
            rd_wen_q   <= 1'b0;
            funct3_q   <= '0;
            addr_lo_q  <= '0;
            rf_wen_q   <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            instret_q  <= '0;
        end else begin
            state_q  <= state_d;
            rf_wen_q <= 1'b0;
            if (accept) begin
                rd_q      <= in_rd;
                rd_wen_q  <= in_rd_wen;
                funct3_q  <= in_ld_funct3;
                addr_lo_q <= in_addr_lo;
            end
            // x0 still retires; only the register-file strobe is suppressed.
            if (retire) begin
                rf_wen_q   <= ret_wen && (ret_rd != 5'd0);
                rf_waddr_q <= ret_rd;
                rf_wdata_q <= ret_data;
                instret_q  <= instret_q + 64'd1;
            end
        end
    end

    assign rf_wen   = rf_wen_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;
    assign instret  = instret_q;

`ifdef YSYX_22050854_WBU_DIFFTEST_EN
    logic [63:0] pc_q;
    logic        commit_valid_q;
    logic [63:0] commit_pc_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q           <= '0;
            commit_valid_q <= 1'b0;
            commit_pc_q    <= '0;
        end else begin
            commit_valid_q <= retire;
            if (accept) begin
                pc_q <= in_pc;
            end
            if (retire) begin
                commit_pc_q <= (state_q == IDLE) ? in_pc : pc_q;
            end
        end
    end

    assign commit_valid = commit_valid_q;
    assign commit_pc    = commit_pc_q;
`else
    logic unused_pc;
    assign unused_pc    = ^in_pc;
    assign commit_valid = 1'b0;
    assign commit_pc    = '0;
`endif

endmodule
